// File: rtl/enigma_step_ctrl.sv
// enigma_step_ctrl: sequencing controller for the rotor datapath.
// Owns the three rotor positions and steps them on every accepted key,
// including the double step of the middle rotor. It launches one datapath pass
// per key and returns the cipher letter over a valid/ready output.
module enigma_step_ctrl #(
    parameter logic [4:0] NOTCH1  = 5'd16,
    parameter logic [4:0] NOTCH2  = 5'd4,
    parameter logic [3:0] TIMEOUT = 4'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [4:0] key_in,
    input  logic       cfg_load,
    input  logic [4:0] cfg_pos1,
    input  logic [4:0] cfg_pos2,
    input  logic [4:0] cfg_pos3,
    output logic       dp_start,
    output logic [4:0] dp_data,
    output logic [4:0] dp_r1,
    output logic [4:0] dp_r2,
    output logic [4:0] dp_r3,
    input  logic       dp_done,
    input  logic [4:0] dp_result,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_data,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STEP  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [4:0] r1_r;
    logic [4:0] r2_r;
    logic [4:0] r3_r;
    logic [4:0] letter_r;
    logic [4:0] out_data_r;
    logic [3:0] cnt_r;
    logic       done_seen_r;
    logic       dp_start_r;
    logic       out_valid_r;
    logic       busy_r;
    logic       err_r;

    logic       in_idle_s;
    logic       cfg_ok_s;
    logic       key_ok_s;
    logic       accept_s;
    logic       done_s;
    logic       tmo_hit_s;
    logic       err_nxt_s;

    // Position increment modulo 26 (Z wraps to A).
    function automatic logic [4:0] inc26(input logic [4:0] v);
        if (v >= 5'd25) begin
            return 5'd0;
        end else begin
            return v + 5'd1;
        end
    endfunction

    // A configuration load takes the IDLE cycle, so a key waits one cycle.
    assign in_idle_s = (state_r == IDLE);
    assign key_ready = in_idle_s & ~cfg_load;
    assign cfg_ok_s  = (cfg_pos1 <= 5'd25) && (cfg_pos2 <= 5'd25) && (cfg_pos3 <= 5'd25);
    assign key_ok_s  = (key_in <= 5'd25);
    assign accept_s  = key_ready & key_valid & key_ok_s;
    // A completion that arrived during ISSUE is remembered in done_seen_r.
    assign done_s    = dp_done | done_seen_r;
    assign tmo_hit_s = (cnt_r == (TIMEOUT - 4'd1));

    assign dp_start  = dp_start_r;
    assign dp_data   = letter_r;
    assign dp_r1     = r1_r;
    assign dp_r2     = r2_r;
    assign dp_r3     = r3_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign err       = err_r;

    // Next-state decode and error pulse request.
    always_comb begin
        state_nxt_s = state_r;
        err_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (cfg_load) begin
                    state_nxt_s = IDLE;
                    err_nxt_s   = ~cfg_ok_s;
                end else if (key_valid) begin
                    if (key_ok_s) begin
                        state_nxt_s = STEP;
                    end else begin
                        state_nxt_s = IDLE;
                        err_nxt_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STEP:  state_nxt_s = ISSUE;
            ISSUE: state_nxt_s = WAIT;
            WAIT: begin
                if (done_s) begin
                    state_nxt_s = OUT;
                end else if (tmo_hit_s) begin
                    state_nxt_s = IDLE;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = OUT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Rotor positions: config load in IDLE, stepping from pre-step values in STEP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1_r <= 5'd0;
            r2_r <= 5'd0;
            r3_r <= 5'd0;
        end else if (in_idle_s && cfg_load && cfg_ok_s) begin
            r1_r <= cfg_pos1;
            r2_r <= cfg_pos2;
            r3_r <= cfg_pos3;
        end else if (state_r == STEP) begin
            r1_r <= inc26(r1_r);
            if ((r1_r == NOTCH1) || (r2_r == NOTCH2)) begin
                r2_r <= inc26(r2_r);
            end
            if (r2_r == NOTCH2) begin
                r3_r <= inc26(r3_r);
            end
        end
    end

    // Latch the accepted letter; it stays on dp_data until the next key.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            letter_r <= 5'd0;
        end else if (accept_s) begin
            letter_r <= key_in;
        end
    end

    // Completion capture and WAIT timeout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r       <= 4'd0;
            done_seen_r <= 1'b0;
            out_data_r  <= 5'd0;
        end else begin
            if (state_r == ISSUE) begin
                cnt_r       <= 4'd0;
                done_seen_r <= dp_done;
                if (dp_done) begin
                    out_data_r <= dp_result;
                end
            end else if (state_r == WAIT) begin
                if (!done_s) begin
                    cnt_r <= cnt_r + 4'd1;
                end
                if (dp_done && !done_seen_r) begin
                    out_data_r <= dp_result;
                end
            end else begin
                done_seen_r <= 1'b0;
            end
        end
    end

    // Registered status/handshake outputs derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_start_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            dp_start_r  <= (state_nxt_s == ISSUE);
            out_valid_r <= (state_nxt_s == OUT);
            busy_r      <= (state_nxt_s != IDLE);
            err_r       <= err_nxt_s;
        end
    end

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Testbench for enigma_step_ctrl: a datapath model answers each launch after a
// programmable latency; expected launches and cipher letters are queued when a
// key is driven and compared when the controller produces them.
module tb_enigma_step_ctrl;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic       key_ready;
    logic [4:0] key_in;
    logic       cfg_load;
    logic [4:0] cfg_pos1, cfg_pos2, cfg_pos3;
    logic       dp_start;
    logic [4:0] dp_data, dp_r1, dp_r2, dp_r3;
    logic       dp_done;
    logic [4:0] dp_result;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_data;
    logic       busy;
    logic       err;

    int errors = 0;
    int checks = 0;
    int elapsed;
    logic [4:0] m1, m2, m3;
    logic [4:0] last_out;
    logic [19:0] exp_pos_q[$];
    logic [4:0]  exp_out_q[$];

    int  dp_lat = 1;
    bit  dp_en = 1'b1;
    int  stray_req = 0;
    int  stray_ack = 0;
    int  dpm_cnt = 0;
    bit  dpm_pending = 1'b0;
    logic [4:0] dpm_res;

    enigma_step_ctrl #(.NOTCH1(5'd16), .NOTCH2(5'd4), .TIMEOUT(4'd15)) dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .cfg_load(cfg_load), .cfg_pos1(cfg_pos1), .cfg_pos2(cfg_pos2), .cfg_pos3(cfg_pos3),
        .dp_start(dp_start), .dp_data(dp_data), .dp_r1(dp_r1), .dp_r2(dp_r2), .dp_r3(dp_r3),
        .dp_done(dp_done), .dp_result(dp_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Stand-in cipher function of the rotor datapath.
    function automatic logic [4:0] dp_fn(input logic [4:0] d, input logic [4:0] a,
                                         input logic [4:0] b, input logic [4:0] c);
        int s;
        s = int'(d) + int'(a) + 2 * int'(b) + 3 * int'(c) + 6;
        return 5'(s % 26);
    endfunction

    function automatic logic [4:0] inc(input logic [4:0] v);
        return (v == 5'd25) ? 5'd0 : v + 5'd1;
    endfunction

    // Reference stepping: r1 always, r2 on r1 notch or its own notch, r3 on r2 notch.
    task automatic model_step();
        logic [4:0] n1, n2, n3;
        n1 = inc(m1);
        n2 = ((m1 == 5'd16) || (m2 == 5'd4)) ? inc(m2) : m2;
        n3 = (m2 == 5'd4) ? inc(m3) : m3;
        m1 = n1; m2 = n2; m3 = n3;
    endtask

    // Datapath model: answers a launch after dp_lat cycles (0 = same cycle).
    initial begin
        dp_done = 1'b0;
        dp_result = 5'd0;
        forever begin
            @(posedge clk); #1;
            dp_done = 1'b0;
            if (dpm_pending) begin
                if (dpm_cnt == 0) begin
                    dp_done = 1'b1; dp_result = dpm_res; dpm_pending = 1'b0;
                end else begin
                    dpm_cnt--;
                end
            end else if (stray_req != stray_ack) begin
                dp_done = 1'b1; dp_result = 5'd20; stray_ack = stray_req;
            end else if (dp_start === 1'b1 && dp_en) begin
                dpm_res = dp_fn(dp_data, dp_r1, dp_r2, dp_r3);
                if (dp_lat == 0) begin
                    dp_done = 1'b1; dp_result = dpm_res;
                end else begin
                    dpm_pending = 1'b1; dpm_cnt = dp_lat - 1;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    task automatic check_pos(input string name);
        checks++;
        if ({dp_r1, dp_r2, dp_r3} !== {m1, m2, m3}) begin
            errors++;
            $display("FAIL %s: got %0d,%0d,%0d want %0d,%0d,%0d", name, dp_r1, dp_r2, dp_r3, m1, m2, m3);
        end
    endtask

    // Drive one key from a negedge in IDLE and check the datapath launch.
    task automatic send_key(input logic [4:0] k, input int lat, input bit en);
        logic [19:0] exp;
        dp_lat = lat; dp_en = en;
        model_step();
        exp_pos_q.push_back({k, m1, m2, m3});
        if (en) exp_out_q.push_back(dp_fn(k, m1, m2, m3));
        key_in = k; key_valid = 1'b1;
        #1;
        checks++;
        if (key_ready !== 1'b1) begin errors++; $display("FAIL send_key_ready: got %b want 1", key_ready); end
        @(negedge clk);
        key_valid = 1'b0;
        elapsed = 1;
        while (dp_start !== 1'b1 && elapsed < 12) begin @(negedge clk); elapsed++; end
        checks++;
        if (elapsed != 2) begin errors++; $display("FAIL dp_start_latency: got %0d want 2", elapsed); end
        exp = exp_pos_q.pop_front();
        checks++;
        if ({dp_data, dp_r1, dp_r2, dp_r3} !== exp) begin
            errors++;
            $display("FAIL dp_launch: got d=%0d r=%0d,%0d,%0d want d=%0d r=%0d,%0d,%0d",
                     dp_data, dp_r1, dp_r2, dp_r3, exp[19:15], exp[14:10], exp[9:5], exp[4:0]);
        end
    endtask

    // Wait for the cipher letter, optionally stall out_ready, then complete the handshake.
    task automatic recv_out(input int lat, input int hold);
        logic [4:0] exp;
        int exp_lat;
        while (out_valid !== 1'b1 && elapsed < 40) begin @(negedge clk); elapsed++; end
        exp_lat = (lat == 0) ? 4 : 3 + lat;
        checks++;
        if (elapsed != exp_lat) begin errors++; $display("FAIL out_latency: got %0d want %0d", elapsed, exp_lat); end
        exp = (exp_out_q.size() > 0) ? exp_out_q.pop_front() : 5'd31;
        last_out = exp;
        checks++;
        if (out_data !== exp || out_valid !== 1'b1) begin
            errors++; $display("FAIL out_data: got %0d valid=%b want %0d", out_data, out_valid, exp);
        end
        checks++;
        if (key_ready !== 1'b0) begin errors++; $display("FAIL out_key_ready: got %b want 0", key_ready); end
        for (int i = 0; i < hold; i++) begin
            key_valid = 1'b1; key_in = 5'd3;
            cfg_load = 1'b1; cfg_pos1 = 5'd1; cfg_pos2 = 5'd2; cfg_pos3 = 5'd3;
            @(negedge clk);
            checks++;
            if ({out_valid, key_ready, err, busy} !== 4'b1001 || out_data !== exp) begin
                errors++;
                $display("FAIL out_hold: got v=%b kr=%b err=%b busy=%b d=%0d want v=1 kr=0 err=0 busy=1 d=%0d",
                         out_valid, key_ready, err, busy, out_data, exp);
            end
        end
        key_valid = 1'b0; cfg_load = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({out_valid, key_ready, busy} !== 3'b010) begin
            errors++; $display("FAIL out_release: got v=%b kr=%b busy=%b want v=0 kr=1 busy=0", out_valid, key_ready, busy);
        end
        check_pos("pos_after_out");
    endtask

    // Drive one configuration load from a negedge in IDLE.
    task automatic do_cfg(input logic [4:0] p1, input logic [4:0] p2, input logic [4:0] p3, input bit bad);
        cfg_load = 1'b1; cfg_pos1 = p1; cfg_pos2 = p2; cfg_pos3 = p3;
        #1;
        checks++;
        if (key_ready !== 1'b0) begin errors++; $display("FAIL cfg_key_ready: got %b want 0", key_ready); end
        @(negedge clk);
        cfg_load = 1'b0;
        if (!bad) begin m1 = p1; m2 = p2; m3 = p3; end
        checks++;
        if (err !== bad) begin errors++; $display("FAIL cfg_err: got %b want %b", err, bad); end
        check_pos("cfg_pos");
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL cfg_err_pulse: got %b want 0", err); end
    endtask

    task automatic test_reset();
        rst = 1'b0; key_valid = 1'b0; key_in = 5'd0; cfg_load = 1'b0;
        cfg_pos1 = 5'd0; cfg_pos2 = 5'd0; cfg_pos3 = 5'd0; out_ready = 1'b0;
        m1 = 5'd0; m2 = 5'd0; m3 = 5'd0; last_out = 5'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({key_ready, dp_start, out_valid, err, busy} !== 5'b10000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 10000", {key_ready, dp_start, out_valid, err, busy});
        end
        checks++;
        if ({out_data, dp_data} !== 10'd0) begin
            errors++; $display("FAIL reset_data: got out=%0d dp=%0d want 0,0", out_data, dp_data);
        end
        check_pos("reset_pos");
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        send_key(5'd0, 2, 1'b1);
        recv_out(2, 0);
        checks++;
        if (last_out !== 5'd7) begin errors++; $display("FAIL basic_cipher: got %0d want 7", last_out); end
    endtask

    task automatic test_cfg_notch();
        do_cfg(5'd16, 5'd0, 5'd0, 1'b0);
        send_key(5'd4, 1, 1'b1);
        recv_out(1, 0);
        do_cfg(5'd25, 5'd3, 5'd25, 1'b0);
        send_key(5'd12, 0, 1'b1);
        recv_out(0, 0);
    endtask

    task automatic test_double_step();
        do_cfg(5'd15, 5'd3, 5'd0, 1'b0);
        send_key(5'd3, 1, 1'b1);  recv_out(1, 0);
        send_key(5'd11, 0, 1'b1); recv_out(0, 0);
        send_key(5'd25, 3, 1'b1); recv_out(3, 0);
        checks++;
        if ({m1, m2, m3} !== {5'd18, 5'd5, 5'd1}) begin
            errors++; $display("FAIL double_step_model: got %0d,%0d,%0d want 18,5,1", m1, m2, m3);
        end
    endtask

    task automatic test_bad_inputs();
        key_in = 5'd27; key_valid = 1'b1;
        #1;
        checks++;
        if (key_ready !== 1'b1) begin errors++; $display("FAIL badkey_ready: got %b want 1", key_ready); end
        @(negedge clk);
        key_valid = 1'b0;
        checks++;
        if ({err, busy, key_ready} !== 3'b101) begin
            errors++; $display("FAIL badkey_err: got err=%b busy=%b kr=%b want 1,0,1", err, busy, key_ready);
        end
        check_pos("badkey_pos");
        @(negedge clk);
        checks++;
        if ({err, dp_start} !== 2'b00) begin
            errors++; $display("FAIL badkey_pulse: got err=%b start=%b want 0,0", err, dp_start);
        end
        do_cfg(5'd1, 5'd30, 5'd2, 1'b1);
        stray_req++;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, busy} !== 2'b00 || out_data !== last_out) begin
            errors++; $display("FAIL stray_done: got v=%b busy=%b d=%0d want 0,0,%0d", out_valid, busy, out_data, last_out);
        end
    endtask

    task automatic test_backpressure();
        send_key(5'd7, 1, 1'b1);
        recv_out(1, 10);
    endtask

    task automatic test_cfg_and_key();
        cfg_load = 1'b1; cfg_pos1 = 5'd5; cfg_pos2 = 5'd6; cfg_pos3 = 5'd7;
        key_valid = 1'b1; key_in = 5'd9;
        #1;
        checks++;
        if (key_ready !== 1'b0) begin errors++; $display("FAIL cfgkey_ready: got %b want 0", key_ready); end
        @(negedge clk);
        cfg_load = 1'b0;
        m1 = 5'd5; m2 = 5'd6; m3 = 5'd7;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL cfgkey_busy: got %b want 0", busy); end
        check_pos("cfgkey_pos");
        send_key(5'd9, 1, 1'b1);
        recv_out(1, 0);
    endtask

    task automatic test_timeout();
        int n;
        bit saw_valid;
        send_key(5'd14, 0, 1'b0);
        n = 0; saw_valid = 1'b0;
        while (err !== 1'b1 && n < 40) begin
            @(negedge clk); n++;
            if (out_valid === 1'b1) saw_valid = 1'b1;
        end
        // WAIT is entered one cycle after the launch, so err shows TIMEOUT+1 cycles after it.
        checks++;
        if (n != TIMEOUT + 1) begin errors++; $display("FAIL timeout_cycles: got %0d want %0d", n, TIMEOUT + 1); end
        checks++;
        if (saw_valid) begin errors++; $display("FAIL timeout_valid: got 1 want 0"); end
        checks++;
        if ({busy, key_ready} !== 2'b01) begin
            errors++; $display("FAIL timeout_idle: got busy=%b kr=%b want 0,1", busy, key_ready);
        end
        check_pos("timeout_pos");
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got %b want 0", err); end
        dp_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit act;
        send_key(5'd21, 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        m1 = 5'd0; m2 = 5'd0; m3 = 5'd0;
        checks++;
        if ({key_ready, dp_start, out_valid, err, busy} !== 5'b10000 || {out_data, dp_data} !== 10'd0) begin
            errors++;
            $display("FAIL async_reset: got ctrl=%b out=%0d dp=%0d want ctrl=10000 out=0 dp=0",
                     {key_ready, dp_start, out_valid, err, busy}, out_data, dp_data);
        end
        check_pos("async_reset_pos");
        @(negedge clk);
        rst = 1'b1;
        act = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (dp_start !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) act = 1'b1;
        end
        checks++;
        if (act) begin errors++; $display("FAIL post_reset_quiet: got activity want none"); end
        dp_en = 1'b1;
        send_key(5'd2, 1, 1'b1);
        recv_out(1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cfg_notch();
        test_double_step();
        test_bad_inputs();
        test_backpressure();
        test_cfg_and_key();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enigma_step_ctrl.md
Name: enigma_step_ctrl

Overview:
- Sequencing controller for the combinational rotor path: forward rotor pass, reflector, backward rotor pass.
- Owns the three rotor position registers and applies Enigma stepping on every keypress, including the double-step anomaly.
- Launches one datapath pass per key using the stepped positions, waits for completion, and returns the cipher letter over a valid/ready output.
- Sits between the keyboard/UART front end and the rotor datapath.

Parameters:
- NOTCH1, 16, r1 position (Q) at which a step of r1 also steps r2
- NOTCH2, 4, r2 position (E) at which r2 and r3 step (double step)
- TIMEOUT, 15, max cycles in WAIT for dp_done before abort; 4-bit counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- key_valid  in  1  key_in holds a letter
- key_ready  out  1  controller accepts a key (IDLE only)
- key_in  in  5  letter 0..25 (A..Z)
- cfg_load  in  1  load starting positions
- cfg_pos1, cfg_pos2, cfg_pos3  in  5 each  new r1/r2/r3 positions
- dp_start  out  1  one-cycle pass launch to rotor datapath
- dp_data  out  5  letter presented to datapath
- dp_r1, dp_r2, dp_r3  out  5 each  positions presented to datapath
- dp_done  in  1  datapath result valid (single-cycle pulse)
- dp_result  in  5  datapath cipher letter
- out_valid  out  1  cipher letter available
- out_ready  in  1  consumer accepts
- out_data  out  5  cipher letter
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse on bad key, bad cfg, or timeout

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; r1=r2=r3=0; key_ready=1; dp_start=0; out_valid=0; out_data=0; dp_data=0; err=0; timeout counter=0.
- States: IDLE, STEP, ISSUE, WAIT, OUT.
- IDLE:
  - key_ready=1.
  - cfg_load=1 has priority over key_valid in the same cycle. It loads positions if all three are ≤25; otherwise positions are unchanged and err pulses. The key is not consumed (key_ready=0 that cycle).
  - Handshake key_valid&key_ready with key_in≤25: latch letter, go to STEP.
  - Handshake with key_in≥26: consume the key, pulse err, stay in IDLE.
- STEP (1 cycle), all updates simultaneous and based on the pre-step values:
  - r1 always increments.
  - r2 increments if r1==NOTCH1 or r2==NOTCH2.
  - r3 increments if r2==NOTCH2.
  - All increments are mod 26 (25→0).
  - Next state: ISSUE.
- ISSUE (1 cycle):
  - dp_start=1; dp_data=latched letter; dp_r1..3 = new positions.
  - Clear timeout counter; go to WAIT.
  - dp_data and dp_r* stay stable from ISSUE until the controller leaves WAIT.
- WAIT:
  - dp_done=1: capture dp_result into out_data, go to OUT.
  - A dp_done seen in the ISSUE cycle is also captured (zero-latency datapath allowed).
  - Counter reaching TIMEOUT with no dp_done: pulse err, go to IDLE, out_valid stays 0. Stepped positions are kept (rotors moved as if the key were pressed).
- OUT:
  - out_valid=1; out_data held stable until out_ready.
  - out_valid&out_ready: go to IDLE the next cycle; key_ready returns high that cycle.
  - Minimum key-to-out_valid latency is 4 cycles (accept, STEP, ISSUE, WAIT with dp_done in the same cycle); OUT is entered on the 4th edge.
- dp_done outside ISSUE/WAIT is ignored.
- cfg_load outside IDLE is ignored, with no err.
- Reset mid-operation aborts immediately to reset values. No output completes and no dp_start is issued.
- dp_r1..3 reflect live positions in all states; r1_final-style positions are not recomputed by the datapath.

Test Plan:
- Reset, key_in=0 with positions 0,0,0; datapath model returns 7 after 2 cycles → dp_start with dp_r1=1, dp_r2=0, dp_r3=0, dp_data=0; out_data=7, out_valid until out_ready.
- cfg 16,0,0 then key → dp_r1=17, dp_r2=1, dp_r3=0. cfg 25,3,25 then key → r1=0, r2=3, r3=25 (wrap, no carry).
- Double step: cfg 15,3,0, press three keys → positions (16,3,0), (17,4,0), (18,5,1).
- key_in=27 → err pulse for 1 cycle, no dp_start, positions unchanged, key_ready stays 1. cfg_pos2=30 → err, positions unchanged.
- Datapath never asserts dp_done → err exactly TIMEOUT cycles after WAIT entry, return to IDLE, positions stay stepped, out_valid never asserted.
- out_ready held low 10 cycles → out_valid/out_data stable, key_ready=0, a new key is not accepted. Assert rst=0 mid-WAIT → all outputs go to reset values asynchronously; cfg_load and key_valid in the same IDLE cycle → cfg applied, key accepted the next cycle.
